// File: rtl/jk_reg_pkg.sv
// Shared definitions for the JK universal register: mode field width and
// the eight operation codes, used by both the block and its bench.
package jk_reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_JK   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_LOAD = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SHL  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_SHR  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_UP   = 3'd5;
    localparam logic [MODE_W-1:0] MODE_DN   = 3'd6;
    localparam logic [MODE_W-1:0] MODE_TGL  = 3'd7;

endpackage : jk_reg_pkg

// File: rtl/jk_bit_next.sv
// One-bit combinational next-state cell: behaves as a JK flop input stage
// when sel=0 and as a T flop input stage when sel=1.
module jk_bit_next (
    input  logic j,
    input  logic k,
    input  logic t,
    input  logic q,
    input  logic sel,
    output logic q_next
);

    // Select between the JK characteristic equation and a plain toggle.
    always_comb begin
        if (sel) begin
            q_next = q ^ t;
        end else begin
            q_next = (j & ~q) | (~k & q);
        end
    end

endmodule : jk_bit_next

// File: rtl/jk_universal_register.sv
// WIDTH-bit universal register: hold, per-bit JK, parallel load, left/right
// shift, up/down count with a wrap pulse, and per-bit toggle. All state lives
// in one clocked process; JK/T bit logic comes from jk_bit_next cells.
module jk_universal_register
    import jk_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  j,
    input  logic [WIDTH-1:0]  k,
    input  logic [WIDTH-1:0]  d,
    input  logic              ser_in,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic              wrap,
    output logic              ser_out
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ser_q;
    logic             ser_d;
    logic [WIDTH-1:0] cell_next;
    logic             tgl_sel;

    assign tgl_sel = (mode == MODE_TGL);

    // Per-bit JK / T next-state cells; j doubles as the toggle input.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_bit_next u_cell (
            .j      (j[i]),
            .k      (k[i]),
            .t      (j[i]),
            .q      (q_q[i]),
            .sel    (tgl_sel),
            .q_next (cell_next[i])
        );
    end

    // Next-state selection for the register, the wrap pulse and the serial output.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned, which would infer a latch.
        q_d    = q_q;
        wrap_d = 1'b0;
        ser_d  = ser_q;
        if (en) begin
            case (mode)
                MODE_JK, MODE_TGL: q_d = cell_next;
                MODE_LOAD:         q_d = d;
                MODE_SHL: begin
                    q_d   = {q_q[WIDTH-2:0], ser_in};
                    ser_d = q_q[WIDTH-1];
                end
                MODE_SHR: begin
                    q_d   = {ser_in, q_q[WIDTH-1:1]};
                    ser_d = q_q[0];
                end
                MODE_UP: begin
                    q_d    = q_q + WIDTH'(1);
                    wrap_d = &q_q;
                end
                MODE_DN: begin
                    q_d    = q_q - WIDTH'(1);
                    wrap_d = ~|q_q;
                end
                default: q_d = q_q;
            endcase
        end
    end

    // State register with synchronous active-low reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            ser_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ser_q  <= ser_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign wrap    = wrap_q;
    assign ser_out = ser_q;

endmodule : jk_universal_register

// File: tb/tb_jk_universal_register.sv
// Directed bench for jk_universal_register at WIDTH=4: one task per scenario,
// plus a background monitor confirming qn is the complement of q every cycle.
module tb_jk_universal_register;
    import jk_reg_pkg::*;

    localparam int W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [MODE_W-1:0] mode;
    logic [W-1:0]      j;
    logic [W-1:0]      k;
    logic [W-1:0]      d;
    logic              ser_in;
    logic [W-1:0]      q;
    logic [W-1:0]      qn;
    logic              wrap;
    logic              ser_out;

    int n_assert = 0;
    int n_fail   = 0;
    bit qn_watch = 1'b0;

    jk_universal_register #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .d       (d),
        .ser_in  (ser_in),
        .q       (q),
        .qn      (qn),
        .wrap    (wrap),
        .ser_out (ser_out)
    );

    always #5 clk = ~clk;

    // qn must equal ~q on every cycle once reset has been applied.
    always @(negedge clk) begin
        if (qn_watch) begin
            n_assert++;
            if (qn !== ~q) begin
                n_fail++;
                $display("FAIL qn_complement: q=%b qn=%b required qn=%b", q, qn, ~q);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_q(input string name, input logic [W-1:0] exp_q, input logic exp_wrap);
        n_assert++;
        if (q !== exp_q) begin
            n_fail++;
            $display("FAIL %s: q=%b required %b", name, q, exp_q);
        end
        n_assert++;
        if (wrap !== exp_wrap) begin
            n_fail++;
            $display("FAIL %s: wrap=%b required %b", name, wrap, exp_wrap);
        end
    endtask

    task automatic load(input logic [W-1:0] val);
        en = 1'b1; mode = MODE_LOAD; d = val;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mode = MODE_UP;
        j = '0; k = '0; d = '0; ser_in = 1'b0;
        tick();
        tick();
        qn_watch = 1'b1;
        expect_q("reset", 4'b0000, 1'b0);
        n_assert++;
        if (qn !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_qn: qn=%b required 1111", qn);
        end
        n_assert++;
        if (ser_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ser_out: ser_out=%b required 0", ser_out);
        end
        rst_n = 1'b1;
        // First edge out of reset counts up from zero.
        tick();
        expect_q("reset_release", 4'b0001, 1'b0);
    endtask

    task automatic test_jk();
        load(4'b1010);
        // bit3: q1 j1 k0 -> 1; bit2: q0 j1 k1 -> 1; bit1: q1 j0 k1 -> 0; bit0: q0 j0 k0 -> 0
        mode = MODE_JK; j = 4'b1100; k = 4'b0110;
        tick();
        expect_q("jk_vec_a", 4'b1100, 1'b0);
        load(4'b1010);
        // bit3 toggle 1->0, bit2 set 0->1, bit1 clear 1->0, bit0 hold 0
        mode = MODE_JK; j = 4'b1100; k = 4'b1010;
        tick();
        expect_q("jk_four_cases", 4'b0100, 1'b0);
        j = '0; k = '0;
    endtask

    task automatic test_count_up();
        load(4'b1110);
        mode = MODE_UP;
        tick();
        expect_q("up_1111", 4'b1111, 1'b0);
        tick();
        expect_q("up_wrap", 4'b0000, 1'b1);
        tick();
        expect_q("up_after_wrap", 4'b0001, 1'b0);
    endtask

    task automatic test_count_down();
        load(4'b0001);
        mode = MODE_DN;
        tick();
        expect_q("dn_0000", 4'b0000, 1'b0);
        tick();
        expect_q("dn_wrap", 4'b1111, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_q("dn_disabled_hold", 4'b1111, 1'b0);
        end
        // Disabled at all-ones in UP mode: no wrap, no change.
        mode = MODE_UP;
        tick();
        expect_q("up_disabled_no_wrap", 4'b1111, 1'b0);
        en = 1'b1;
    endtask

    task automatic test_shift();
        load(4'b1011);
        mode = MODE_SHL; ser_in = 1'b0;
        tick();
        expect_q("shl", 4'b0110, 1'b0);
        n_assert++;
        if (ser_out !== 1'b1) begin
            n_fail++;
            $display("FAIL shl_ser_out: ser_out=%b required 1", ser_out);
        end
        mode = MODE_HOLD;
        tick();
        expect_q("hold", 4'b0110, 1'b0);
        n_assert++;
        if (ser_out !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_ser_out: ser_out=%b required 1", ser_out);
        end
        mode = MODE_SHR; ser_in = 1'b1;
        tick();
        expect_q("shr", 4'b1011, 1'b0);
        n_assert++;
        if (ser_out !== 1'b0) begin
            n_fail++;
            $display("FAIL shr_ser_out: ser_out=%b required 0", ser_out);
        end
        ser_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        load(4'b1111);
        mode = MODE_UP;
        tick();
        expect_q("b2b_up_wrap", 4'b0000, 1'b1);
        mode = MODE_DN;
        tick();
        expect_q("b2b_dn_wrap", 4'b1111, 1'b1);
        mode = MODE_UP;
        tick();
        expect_q("b2b_up_wrap2", 4'b0000, 1'b1);
    endtask

    task automatic test_mid_reset();
        // Leave ser_out high so reset has something to clear.
        load(4'b1101);
        mode = MODE_SHL; ser_in = 1'b1;
        tick();
        n_assert++;
        if (ser_out !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_ser_out: ser_out=%b required 1", ser_out);
        end
        ser_in = 1'b0;
        load(4'b0101);
        mode = MODE_UP;
        tick();
        expect_q("mid_up1", 4'b0110, 1'b0);
        tick();
        expect_q("mid_up2", 4'b0111, 1'b0);
        rst_n = 1'b0;
        tick();
        expect_q("mid_reset", 4'b0000, 1'b0);
        n_assert++;
        if (ser_out !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ser_out: ser_out=%b required 0", ser_out);
        end
        rst_n = 1'b1;
        tick();
        expect_q("mid_release", 4'b0001, 1'b0);
        mode = MODE_DN;
        tick();
        expect_q("mid_dn_zero", 4'b0000, 1'b0);
        mode = MODE_TGL; j = 4'b0101; k = 4'b1111;
        tick();
        expect_q("tgl", 4'b0101, 1'b0);
        j = '0; k = '0;
    endtask

    initial begin
        test_reset();
        test_jk();
        test_count_up();
        test_count_down();
        test_shift();
        test_back_to_back();
        test_mid_reset();
        qn_watch = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_jk_universal_register
